ring_decoder: RTL and testbench

Consumes a WIDTH-bit one-hot ring counter, clocked by a pushbutton and asynchronous to the system clock, and turns it into clean system-clock information. It synchronizes and filters the ring, encodes the hot position in binary, emits step and wrap pulses, and counts completed laps. It checks every transition against the legal rotation (bit i → bit i+1, MSB → bit 0) and flags faults. It sits between the flip-flop ring and the display/UART logic in `top`.

---
 rtl/ring_decoder.sv | 92 +++++++++
 tb/tb_ring_decoder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ring_decoder.sv
// ring_decoder: synchronizes, filters and validates a one-hot ring counter, reporting position, steps, laps and faults.
module ring_decoder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     hz100,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         ring,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     valid,
  output logic                     step,
  output logic                     wrap,
  output logic [CNT_W-1:0]         laps,
  output logic                     err,
  output logic [1:0]               err_code
);
  localparam int PW = $clog2(WIDTH);
  typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;
  state_t state;
  logic [WIDTH-1:0] s1, s2, s3;
  logic [PW-1:0] idx, nxt;
  logic accept, hot, last;
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) idx = s2[i] ? PW'(i) : idx;
  end
  assign accept = s2 == s3;
  assign hot    = s2 != '0 && (s2 & (s2 - 1'b1)) == '0;
  assign last   = pos == PW'(WIDTH - 1);
  assign nxt    = last ? '0 : pos + 1'b1;
  always_ff @(posedge hz100) begin
    if (reset) begin
      state    <= INIT;
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      pos      <= '0;
      valid    <= 1'b0;
      step     <= 1'b0;
      wrap     <= 1'b0;
      laps     <= '0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      s1   <= ring;
      s2   <= s1;
      s3   <= s2;
      step <= 1'b0;
      wrap <= 1'b0;
      if (accept) begin
        case (state)
          INIT: begin
            if (hot) begin
              pos   <= idx;
              valid <= 1'b1;
              state <= TRACK;
            end else if (s2 != '0) begin
              state <= FAULT;
              if (!err) begin
                err      <= 1'b1;
                err_code <= 2'b01;
              end
            end
          end
          TRACK: begin
            if (s2 == (WIDTH'(1) << nxt)) begin
              pos  <= nxt;
              step <= 1'b1;
              wrap <= last;
              laps <= last ? laps + 1'b1 : laps;
            end else if (s2 != (WIDTH'(1) << pos)) begin
              state <= FAULT;
              valid <= 1'b0;
              if (!err) begin
                err      <= 1'b1;
                err_code <= hot ? 2'b10 : 2'b01;
              end
            end
          end
          default: begin
            // only the ring's own reset state re-establishes a trustworthy position
            if (s2 == WIDTH'(1)) begin
              pos   <= '0;
              valid <= 1'b1;
              state <= TRACK;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder: directed and random checks of ring_decoder against an index-based reference model.
module tb_ring_decoder;
  localparam int W = 4;
  logic hz100 = 1'b0;
  logic reset;
  logic [W-1:0] ring;
  logic [1:0] pos;
  logic valid, step, wrap, err;
  logic [7:0] laps;
  logic [1:0] err_code;
  int vectors = 0, miscompares = 0, nstep = 0, nwrap = 0;
  int mstate, mpos, mvalid, mstep, mwrap, mlaps, merr, mcode;
  int hist[$];
  logic [W-1:0] cur, v;

  ring_decoder #(.WIDTH(W), .CNT_W(8)) dut (
    .hz100(hz100), .reset(reset), .ring(ring), .pos(pos), .valid(valid), .step(step),
    .wrap(wrap), .laps(laps), .err(err), .err_code(err_code)
  );

  always #5 hz100 = ~hz100;

  function automatic int idx_of(int x);
    int r = 0;
    for (int i = 0; i < W; i++) if (x == (1 << i)) r = i;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fault(input int code);
    mstate = 2;
    mvalid = 0;
    if (merr == 0) begin
      merr  = 1;
      mcode = code;
    end
  endtask

  task automatic model(input int r, input int rst);
    int a, ones;
    if (rst != 0) begin
      {mstate, mpos, mvalid, mstep, mwrap, mlaps, merr, mcode} = '0;
      hist = '{0, 0, 0};
      return;
    end
    hist.push_back(r);
    if (hist.size() > 4) void'(hist.pop_front());
    mstep = 0;
    mwrap = 0;
    // a value counts once it was seen identically on two successive synchronized cycles
    if (hist[1] != hist[0]) return;
    a = hist[1];
    ones = $countones(a[W-1:0]);
    if (mstate == 0) begin
      if (ones == 1) begin
        mpos = idx_of(a);
        mvalid = 1;
        mstate = 1;
      end else if (a != 0) fault(1);
    end else if (mstate == 1) begin
      if (a == (1 << mpos)) begin
      end else if (ones == 1 && idx_of(a) == (mpos + 1) % W) begin
        mstep = 1;
        if (mpos == W - 1) begin
          mwrap = 1;
          mlaps = (mlaps + 1) % 256;
        end
        mpos = idx_of(a);
      end else fault(ones == 1 ? 2 : 1);
    end else if (a == 1) begin
      mstate = 1;
      mpos = 0;
      mvalid = 1;
    end
  endtask

  task automatic cyc(input logic [W-1:0] r, input logic rst = 1'b0);
    ring  = r;
    reset = rst;
    @(posedge hz100);
    model(int'(r), int'(rst));
    #1;
    nstep += int'(step);
    nwrap += int'(wrap);
    chk("outputs", {pos, valid, step, wrap, laps, err, err_code},
        {mpos[1:0], mvalid[0], mstep[0], mwrap[0], mlaps[7:0], merr[0], mcode[1:0]});
  endtask

  task automatic hold(input logic [W-1:0] r, input int n);
    repeat (n) cyc(r);
  endtask

  initial begin
    ring  = '0;
    reset = 1'b1;
    cyc('0, 1'b1);
    hold(4'b0000, 10);
    chk("reset_state", {pos, valid, step, wrap, laps, err, err_code}, '0);
    hold(4'b0001, 3);
    chk("no_valid_early", valid, 1'b0);
    cyc(4'b0001);
    chk("load_valid", {valid, pos, step}, {1'b1, 2'd0, 1'b0});
    hold(4'b0001, 3);
    for (int k = 1; k <= 4; k++) begin
      v = 4'b0001 << (k % 4);
      hold(v, 3);
      cyc(v);
      chk("step_pulse", {step, pos}, {1'b1, 2'(k % 4)});
      chk("wrap_pulse", {wrap, laps}, k == 4 ? {1'b1, 8'd1} : {1'b0, 8'd0});
      cyc(v);
      chk("step_one_cycle", {step, wrap}, 2'b00);
    end
    hold(4'b0010, 5);
    chk("at_pos1", pos, 2'd1);
    nstep = 0;
    cyc(4'b1010);
    hold(4'b0010, 6);
    chk("glitch_ignored", {err, pos, valid, 4'(nstep)}, {1'b0, 2'd1, 1'b1, 4'd0});
    hold(4'b1000, 5);
    chk("skip_fault", {err, err_code, valid}, {1'b1, 2'b10, 1'b0});
    hold(4'b0110, 5);
    chk("first_code_kept", {err, err_code}, {1'b1, 2'b10});
    hold(4'b0001, 5);
    chk("recover", {valid, pos, err, err_code}, {1'b1, 2'd0, 1'b1, 2'b10});
    cyc('0, 1'b1);
    hold(4'b0001, 5);
    nstep = 0;
    nwrap = 0;
    for (int l = 0; l < 256; l++)
      for (int k = 1; k <= 4; k++) hold(4'b0001 << (k % 4), 3);
    hold(4'b0001, 3);
    chk("laps_wrapped", laps, 8'd0);
    chk("wrap_count", nwrap, 256);
    chk("step_count", nstep, 1024);
    hold(4'b0010, 5);
    chk("pre_reset_pos", {valid, pos}, {1'b1, 2'd1});
    cyc(4'b0100);
    cyc(4'b0100, 1'b1);
    chk("mid_reset", {pos, valid, step, wrap, laps, err, err_code}, '0);
    nstep = 0;
    hold(4'b0100, 5);
    chk("reload_pos2", {valid, pos, err, 4'(nstep)}, {1'b1, 2'd2, 1'b0, 4'd0});
    cur = 4'b0100;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10: cur = {cur[W-2:0], cur[W-1]};
        11, 12:     cur = 4'b0001;
        13, 14, 15: cur = W'($urandom_range(0, 15));
        16:         cyc(cur, 1'b1);
        default: ;
      endcase
      hold(cur, $urandom_range(1, 4));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
